// File: rtl/ex_result_collect_wb.sv
// Execute-result collector: AND-OR merges the valid result lanes into one
// writeback word and queues it in a 2-entry skid buffer toward writeback.
module ex_result_collect_wb #(
  parameter int INPUTNUM = 7,
  parameter int BITWIDTH = 32,
  parameter int REGADDRW = 5,
  parameter int CNTW     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [INPUTNUM*BITWIDTH-1:0] iResData,
  input  logic [INPUTNUM-1:0]          iResValid,
  input  logic                         iInstValid,
  input  logic [REGADDRW-1:0]          iRdAddr,
  input  logic                         iRdWrEn,
  input  logic                         iFlush,
  output logic                         oReady,
  input  logic                         iWbReady,
  output logic                         oWbValid,
  output logic [BITWIDTH-1:0]          oWbData,
  output logic [REGADDRW-1:0]          oWbRdAddr,
  output logic                         oWbRdWrEn,
  output logic                         oMultiHit,
  output logic [CNTW-1:0]              oMultiHitCnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [BITWIDTH-1:0] data;
    logic [REGADDRW-1:0] addr;
    logic                wren;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic             multi_hit_q, multi_hit_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic [BITWIDTH-1:0] merged;
  logic                multi_lane;
  logic                push, pop;
  entry_t              new_entry;

  always_comb begin
    merged = '0;
    for (int k = 0; k < INPUTNUM; k++) begin
      merged = merged | (iResData[k*BITWIDTH +: BITWIDTH] & {BITWIDTH{iResValid[k]}});
    end
  end

  // Clearing the lowest set bit leaves something only when two or more lanes are set.
  assign multi_lane = |(iResValid & (iResValid - INPUTNUM'(1)));

  assign new_entry = '{data: merged, addr: iRdAddr, wren: iRdWrEn};

  assign oReady   = (state_q != S_FULL);
  assign oWbValid = (state_q != S_EMPTY);
  assign push     = iInstValid & oReady & ~iFlush;
  assign pop      = oWbValid & iWbReady & ~iFlush;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    multi_hit_d = push & multi_lane;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          state_d = S_FULL;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    // Flush only drops occupancy; the head payload registers keep their value.
    if (iFlush) state_d = S_EMPTY;

    if (multi_hit_d && (cnt_q != {CNTW{1'b1}})) cnt_d = cnt_q + CNTW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      head_q      <= '0;
      // NOTE: the tail slot is never observed before being written, but it is
      // cleared with the rest so reset leaves no stale payload anywhere.
      tail_q      <= '0;
      multi_hit_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      multi_hit_q <= multi_hit_d;
      cnt_q       <= cnt_d;
    end
  end

  assign oWbData      = head_q.data;
  assign oWbRdAddr    = head_q.addr;
  assign oWbRdWrEn    = head_q.wren;
  assign oMultiHit    = multi_hit_q;
  assign oMultiHitCnt = cnt_q;

endmodule

// File: tb/tb_ex_result_collect_wb.sv
// Self-checking bench for ex_result_collect_wb: directed vector table, saturation
// and reset sequences, then random traffic against a queue-based reference model.
module tb_ex_result_collect_wb;

  localparam int INPUTNUM = 7;
  localparam int BITWIDTH = 32;
  localparam int REGADDRW = 5;
  localparam int CNTW     = 8;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [INPUTNUM*BITWIDTH-1:0] iResData;
  logic [INPUTNUM-1:0]          iResValid;
  logic                         iInstValid;
  logic [REGADDRW-1:0]          iRdAddr;
  logic                         iRdWrEn;
  logic                         iFlush;
  logic                         oReady;
  logic                         iWbReady;
  logic                         oWbValid;
  logic [BITWIDTH-1:0]          oWbData;
  logic [REGADDRW-1:0]          oWbRdAddr;
  logic                         oWbRdWrEn;
  logic                         oMultiHit;
  logic [CNTW-1:0]              oMultiHitCnt;

  ex_result_collect_wb #(
    .INPUTNUM(INPUTNUM), .BITWIDTH(BITWIDTH), .REGADDRW(REGADDRW), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .iResData(iResData), .iResValid(iResValid),
    .iInstValid(iInstValid), .iRdAddr(iRdAddr), .iRdWrEn(iRdWrEn), .iFlush(iFlush),
    .oReady(oReady), .iWbReady(iWbReady), .oWbValid(oWbValid), .oWbData(oWbData),
    .oWbRdAddr(oWbRdAddr), .oWbRdWrEn(oWbRdWrEn), .oMultiHit(oMultiHit),
    .oMultiHitCnt(oMultiHitCnt)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Layout: ready, valid, wren, addr, data, multihit, count.
  function automatic logic [63:0] pack(input logic rdy, input logic vld, input logic wen,
                                       input logic [4:0] adr, input logic [31:0] dat,
                                       input logic mh, input logic [7:0] cnt);
    return {15'd0, rdy, vld, wen, adr, dat, mh, cnt};
  endfunction

  function automatic logic [63:0] dut_out();
    return pack(oReady, oWbValid, oWbRdWrEn, oWbRdAddr, oWbData, oMultiHit, oMultiHitCnt);
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        wren;
  } ent_t;

  ent_t m_q[$];
  ent_t m_shown;
  int   m_cnt;
  bit   m_mh;

  function automatic logic [31:0] lane(input int k);
    return iResData[k*BITWIDTH +: BITWIDTH];
  endfunction

  task automatic model_update();
    ent_t e;
    bit   can_take, do_push, do_pop;
    if (!rst_n) begin
      m_q.delete();
      m_shown = '0;
      m_cnt   = 0;
      m_mh    = 0;
    end else begin
      e.data = '0;
      for (int k = 0; k < INPUTNUM; k++) if (iResValid[k]) e.data = e.data | lane(k);
      e.addr = iRdAddr;
      e.wren = iRdWrEn;
      can_take = (m_q.size() < 2);
      do_push  = iInstValid && can_take && !iFlush;
      do_pop   = (m_q.size() > 0) && iWbReady && !iFlush;
      m_mh     = do_push && ($countones(iResValid) > 1);
      if (m_mh && m_cnt < 255) m_cnt++;
      if (iFlush) m_q.delete();
      else begin
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(e);
      end
      if (m_q.size() > 0) m_shown = m_q[0];
    end
  endtask

  function automatic logic [63:0] model_out();
    return pack(m_q.size() < 2, m_q.size() > 0, m_shown.wren, m_shown.addr,
                m_shown.data, m_mh, 8'(m_cnt));
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Non-selected lanes carry garbage so masking is exercised.
  task automatic set_lanes(input int la, input logic [31:0] va, input int lb, input logic [31:0] vb);
    for (int k = 0; k < INPUTNUM; k++) iResData[k*BITWIDTH +: BITWIDTH] = 32'hDEAD_0000 | 32'(k);
    if (la >= 0) iResData[la*BITWIDTH +: BITWIDTH] = va;
    if (lb >= 0) iResData[lb*BITWIDTH +: BITWIDTH] = vb;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    bit          inst;
    logic [6:0]  rv;
    int          la;
    logic [31:0] va;
    int          lb;
    logic [31:0] vb;
    logic [4:0]  rd;
    bit          wren;
    bit          flush;
    bit          wbr;
    bit          e_ready;
    bit          e_valid;
    logic [31:0] e_data;
    logic [4:0]  e_addr;
    bit          e_wren;
    bit          e_mh;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{"push_a5",        1, 7'b0001000, 3, 32'hA5, -1, 0,     5'd7, 1, 0, 1, 1, 1, 32'hA5, 5'd7, 1, 0, 8'd0};
    vecs[1]  = '{"pop_a5",         0, 7'b0000000,-1, 0,     -1, 0,     5'd0, 0, 0, 1, 1, 0, 32'hA5, 5'd7, 1, 0, 8'd0};
    vecs[2]  = '{"push_11_stall",  1, 7'b0000001, 0, 32'h11, -1, 0,    5'd1, 1, 0, 0, 1, 1, 32'h11, 5'd1, 1, 0, 8'd0};
    vecs[3]  = '{"push_22_full",   1, 7'b0000010, 1, 32'h22, -1, 0,    5'd2, 1, 0, 0, 0, 1, 32'h11, 5'd1, 1, 0, 8'd0};
    vecs[4]  = '{"ignored_push",   1, 7'b0000100, 2, 32'h99, -1, 0,    5'd3, 1, 0, 0, 0, 1, 32'h11, 5'd1, 1, 0, 8'd0};
    vecs[5]  = '{"pop_11",         0, 7'b0000000,-1, 0,     -1, 0,     5'd0, 0, 0, 1, 1, 1, 32'h22, 5'd2, 1, 0, 8'd0};
    vecs[6]  = '{"push_pop_33",    1, 7'b0010000, 4, 32'h33, -1, 0,    5'd4, 1, 0, 1, 1, 1, 32'h33, 5'd4, 1, 0, 8'd0};
    vecs[7]  = '{"multihit_push",  1, 7'b0000101, 0, 32'hF0, 2, 32'h0F, 5'd5, 0, 0, 0, 0, 1, 32'h33, 5'd4, 1, 1, 8'd1};
    vecs[8]  = '{"pop_33",         0, 7'b0000000,-1, 0,     -1, 0,     5'd0, 0, 0, 1, 1, 1, 32'hFF, 5'd5, 0, 0, 8'd1};
    vecs[9]  = '{"push_noresult",  1, 7'b0000000,-1, 0,     -1, 0,     5'd6, 1, 0, 0, 0, 1, 32'hFF, 5'd5, 0, 0, 8'd1};
    vecs[10] = '{"flush_full",     1, 7'b0000011,-1, 0,     -1, 0,     5'd9, 1, 1, 1, 1, 0, 32'hFF, 5'd5, 0, 0, 8'd1};
    vecs[11] = '{"push_zero_data", 1, 7'b0000000,-1, 0,     -1, 0,     5'd6, 1, 0, 0, 1, 1, 32'h0,  5'd6, 1, 0, 8'd1};
    vecs[12] = '{"pop_zero_data",  0, 7'b0000000,-1, 0,     -1, 0,     5'd0, 0, 0, 1, 1, 0, 32'h0,  5'd6, 1, 0, 8'd1};
  end

  initial begin
    rst_n = 1'b0; iInstValid = 0; iResValid = '0; iRdAddr = '0; iRdWrEn = 0;
    iFlush = 0; iWbReady = 0;
    set_lanes(-1, 0, -1, 0);
    #1;
    step();
    step();
    check("reset_state", dut_out(), pack(1, 0, 0, 5'd0, 32'd0, 0, 8'd0));
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      iInstValid = vecs[i].inst;
      iResValid  = vecs[i].rv;
      set_lanes(vecs[i].la, vecs[i].va, vecs[i].lb, vecs[i].vb);
      iRdAddr    = vecs[i].rd;
      iRdWrEn    = vecs[i].wren;
      iFlush     = vecs[i].flush;
      iWbReady   = vecs[i].wbr;
      step();
      check(vecs[i].name, dut_out(),
            pack(vecs[i].e_ready, vecs[i].e_valid, vecs[i].e_wren, vecs[i].e_addr,
                 vecs[i].e_data, vecs[i].e_mh, vecs[i].e_cnt));
    end

    // Counter saturation: 300 multi-hit pushes while writeback drains each cycle.
    iInstValid = 1; iResValid = 7'b0000101; set_lanes(0, 32'hF0, 2, 32'h0F);
    iRdAddr = 5'd5; iRdWrEn = 0; iFlush = 0; iWbReady = 1;
    for (int n = 0; n < 300; n++) begin
      step();
      if (n % 50 == 0) check($sformatf("sat_step_%0d", n), dut_out(), model_out());
    end
    check("sat_count_255", 64'(oMultiHitCnt), 64'd255);
    check("sat_data_ff", 64'(oWbData), 64'hFF);

    // Fill to FULL, then reset in the middle of traffic.
    iWbReady = 0; iResValid = 7'b1000000; set_lanes(6, 32'h44, -1, 0); iRdAddr = 5'd8; iRdWrEn = 1;
    step();
    check("full_before_reset", 64'(oReady), 64'd0);
    rst_n = 0; iWbReady = 1;
    step();
    check("reset_mid_op", dut_out(), pack(1, 0, 0, 5'd0, 32'd0, 0, 8'd0));
    rst_n = 1; iInstValid = 0;
    step();
    check("after_reset_idle", dut_out(), model_out());

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < INPUTNUM; k++) iResData[k*BITWIDTH +: BITWIDTH] = $urandom;
      case ($urandom_range(0, 9))
        0:       iResValid = '0;
        1, 2:    iResValid = 7'($urandom);
        default: iResValid = 7'(1 << $urandom_range(0, INPUTNUM - 1));
      endcase
      iInstValid = ($urandom_range(0, 3) != 0);
      iRdAddr    = 5'($urandom);
      iRdWrEn    = 1'($urandom);
      iFlush     = ($urandom_range(0, 15) == 0);
      iWbReady   = 1'($urandom);
      rst_n      = ($urandom_range(0, 127) != 0);
      step();
      check($sformatf("rand_%0d", n), dut_out(), model_out());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
